// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode seven-segment scanner with a single-entry
// pending buffer so that a new value only ever takes effect on a frame boundary.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iValue,
  input  logic        iValid,
  output logic        oReady,
  input  logic [7:0]  iBlank,
  output logic [7:0]  oSel,
  output logic [6:0]  oSeg,
  output logic        oFrame
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_q;

  logic        tick;
  logic        boundary;
  logic        accept;
  logic [31:0] src;
  logic [3:0]  nib;
  logic [6:0]  seg_dec;

  assign tick     = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign boundary = tick && (idx_q == 3'd7);
  assign accept   = iValid && !pend_valid_q;

  assign oReady = ~pend_valid_q;
  assign oSel   = sel_q;
  assign oSeg   = seg_q;
  assign oFrame = frame_q;

  // Digit 0 of a new frame must already show the value being applied on this edge.
  assign src = (boundary && pend_valid_q) ? pend_q : disp_q;
  assign nib = src[{idx_d, 2'b00} +: 4];

  always_comb begin
    seg_dec = 7'h7F;
    unique case (nib)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q + 3'd1;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    sel_d        = sel_q;
    seg_d        = seg_q;

    if (tick) begin
      if (iBlank[idx_d]) begin
        sel_d = 8'hFF;
        seg_d = 7'h7F;
      end else begin
        sel_d = ~(8'h01 << idx_d);
        seg_d = seg_dec;
      end
    end

    // accept and a boundary apply are exclusive: accept needs the buffer empty.
    if (accept) begin
      pend_d       = iValue;
      pend_valid_d = 1'b1;
    end else if (boundary && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      disp_q       <= 32'h0;
      pend_q       <= 32'h0;
      pend_valid_q <= 1'b0;
      sel_q        <= 8'hFE;
      seg_q        <= 7'h40;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      if (tick) idx_q <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_q      <= boundary;
    end
  end

endmodule
